rs_latch_sequencer: RTL

- Sequencer and arbiter for a shared gated RS latch (inputs S, R, gate clock; outputs Q, Qn).
- Accepts set, reset and toggle commands from N requesters and grants them round-robin.
- Drives the latch's S, R and gate with a legal, timed pulse, then reads Q/Qn back and reports done or error.
- Ensures S and R are never asserted together.

---
 rtl/rs_latch_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/rs_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rs_latch_sequencer
// Brief    : Round-robin arbiter and pulse sequencer for a shared gated RS
//            latch. Grants one set/reset/toggle command at a time, drives
//            S/R with the gate for HOLD_CYC cycles, idles for SETTLE_CYC
//            cycles, then checks Q/Qn and reports done/err.
// Options  : RS_SEQ_TOGGLE_EN - when defined, cmd 11 toggles the latch
//            (direction picked from Q_in at acceptance); when undefined,
//            cmd 11 is rejected exactly like cmd 00.
// Revision : 1.0 - initial release
// ============================================================================
module rs_latch_sequencer #(
    parameter int N          = 4,
    parameter int HOLD_CYC   = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N-1:0]         req_valid,
    input  logic [2*N-1:0]       req_cmd,
    output logic [N-1:0]         req_ready,
    output logic                 S_out,
    output logic                 R_out,
    output logic                 gate_out,
    input  logic                 Q_in,
    input  logic                 Qn_in,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 done,
    output logic                 err
);

    localparam int c_IDW  = $clog2(N);
    localparam int c_MAXC = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
    localparam int c_CW   = $clog2(c_MAXC + 1);

    localparam logic [c_CW-1:0]  c_HOLD_LD   = c_CW'(HOLD_CYC - 1);
    localparam logic [c_CW-1:0]  c_SETTLE_LD = c_CW'(SETTLE_CYC - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE   = c_CW'(1);
    localparam logic [c_IDW-1:0] c_ID_LAST   = c_IDW'(N - 1);
    localparam logic [c_IDW-1:0] c_ID_ONE    = c_IDW'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DRIVE  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;
    localparam logic [1:0] c_ST_CHECK  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] w_ptr_nxt;
    logic [c_IDW-1:0] r_gid;
    logic             r_dir;      // 1 = drive S (expect Q=1), 0 = drive R
    logic             r_illegal;
    logic             r_s;
    logic             r_r;
    logic             r_gate;

    logic             w_any;
    logic [c_IDW-1:0] w_g;
    logic [1:0]       w_cmd;
    logic             w_legal;
    logic             w_dir;
    logic             w_accept;
    logic             w_drv_dir;

    // Index offset from the pointer, wrapped back into 0..N-1.
    function automatic logic [c_IDW-1:0] f_wrap(input int v);
        int t;
        t = (v >= N) ? (v - N) : v;
        return t[c_IDW-1:0];
    endfunction

    // Round-robin search: scanning offsets downward leaves the lowest valid offset from the pointer.
    always_comb begin
        w_any = 1'b0;
        w_g   = r_ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[f_wrap(int'(r_ptr) + i)]) begin
                w_any = 1'b1;
                w_g   = f_wrap(int'(r_ptr) + i);
            end
        end
    end

    assign w_cmd = req_cmd[{w_g, 1'b0} +: 2];

    // Command decode; toggle picks the direction that flips the current Q.
    always_comb begin
        w_legal = 1'b0;
        w_dir   = 1'b0;
        case (w_cmd)
            2'b01: begin
                w_legal = 1'b1;
                w_dir   = 1'b1;
            end
            2'b10: begin
                w_legal = 1'b1;
                w_dir   = 1'b0;
            end
`ifdef RS_SEQ_TOGGLE_EN
            2'b11: begin
                w_legal = 1'b1;
                w_dir   = ~Q_in;
            end
`endif
            default: begin
                w_legal = 1'b0;
                w_dir   = 1'b0;
            end
        endcase
    end

    assign w_accept = (r_state == c_ST_IDLE) && w_any;

    // Next-state, phase counter and pointer update.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    if (w_legal) begin
                        w_state_nxt = c_ST_DRIVE;
                        w_cnt_nxt   = c_HOLD_LD;
                    end else begin
                        w_state_nxt = c_ST_CHECK;
                    end
                end
            end
            c_ST_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_SETTLE;
                    w_cnt_nxt   = c_SETTLE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_CHECK: begin
                w_state_nxt = c_ST_IDLE;
                w_ptr_nxt   = (r_gid == c_ID_LAST) ? '0 : (r_gid + c_ID_ONE);
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM state, counter and round-robin pointer registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Capture the granted requester and its resolved command at acceptance.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_gid     <= '0;
            r_dir     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_gid     <= w_g;
            r_dir     <= w_dir;
            r_illegal <= ~w_legal;
        end
    end

    assign w_drv_dir = w_accept ? w_dir : r_dir;

    // Registered latch drive: only ever one of S/R, and only while the gate is high.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s    <= 1'b0;
            r_r    <= 1'b0;
            r_gate <= 1'b0;
        end else begin
            r_s    <= (w_state_nxt == c_ST_DRIVE) &&  w_drv_dir;
            r_r    <= (w_state_nxt == c_ST_DRIVE) && !w_drv_dir;
            r_gate <= (w_state_nxt == c_ST_DRIVE);
        end
    end

    // Accept pulse is combinational in the granting IDLE cycle; reset masks it at once.
    generate
        for (genvar j = 0; j < N; j++) begin : g_ready
            assign req_ready[j] = w_accept && !Rst && (w_g == c_IDW'(j));
        end
    endgenerate

    assign S_out    = r_s;
    assign R_out    = r_r;
    assign gate_out = r_gate;
    assign busy     = (r_state != c_ST_IDLE);
    assign grant_id = r_gid;
    assign done     = (r_state == c_ST_CHECK);
    assign err      = done && (r_illegal || (Q_in != r_dir) || (Q_in == Qn_in));

endmodule

`default_nettype wire
